// File: rtl/ram_fill_scan_pkg.sv
// Shared mode and state encodings for the RAM fill/scan controller.
package ram_fill_scan_pkg;

   typedef logic [1:0] state_t;

   localparam logic [1:0] MODE_MANUAL = 2'b00;
   localparam logic [1:0] MODE_FILL   = 2'b01;
   localparam logic [1:0] MODE_SCAN   = 2'b10;

   localparam state_t IDLE = 2'd0;
   localparam state_t FILL = 2'd1;
   localparam state_t SCAN = 2'd2;

endpackage

// File: rtl/ram_fill_scan_ram_sp.sv
// Single-port inferred RAM: address registered each edge, q follows one edge later.
// A write to the word being read returns the old contents on q.
module ram_sp #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   output logic [ADDR_W-1:0] addr_q,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

   // Array storage; deliberately not reset so contents survive a reset.
   always_ff @(posedge clock) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   // Registered address and read data.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_q <= {ADDR_W{1'b0}};
         q      <= {DATA_W{1'b0}};
      end else begin
         addr_q <= addr;
         q      <= mem[addr_q];
      end
   end

endmodule

// File: rtl/ram_fill_scan.sv
// Control FSM over a single-port RAM: manual access, whole-array block fill,
// and a divider-timed scan readback for a display.
module ram_fill_scan
   import ram_fill_scan_pkg::*;
#(
   parameter int DATA_W   = 4,
   parameter int ADDR_W   = 5,
   parameter int SCAN_DIV = 50000000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        mode,
   input  logic              start,
   input  logic              stop,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wren,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] cur_addr,
   output logic [DATA_W-1:0] q,
   output logic              step
);

   // A one-cycle divider still needs a one-bit register that simply stays at zero.
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

   state_t            state, state_nx;
   logic [ADDR_W-1:0] fill_cnt, fill_cnt_nx;
   logic [DATA_W-1:0] fill_val, fill_val_nx;
   logic [DIV_W-1:0]  div_cnt, div_nx;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic              done_nx, step_nx;

   // Next-state, RAM port and pulse decode.
   always_comb begin
      state_nx    = state;
      fill_cnt_nx = fill_cnt;
      fill_val_nx = fill_val;
      div_nx      = div_cnt;
      ram_addr    = cur_addr;
      ram_we      = 1'b0;
      ram_wdata   = wdata;
      done_nx     = 1'b0;
      step_nx     = 1'b0;
      case (state)
         IDLE: begin
            ram_addr = addr;
            ram_we   = wren;
            if (stop) begin
               state_nx = IDLE;
            end else if (start) begin
               case (mode)
                  MODE_FILL: begin
                     state_nx    = FILL;
                     fill_val_nx = wdata;
                     fill_cnt_nx = {ADDR_W{1'b0}};
                  end
                  MODE_SCAN: begin
                     state_nx = SCAN;
                     ram_addr = {ADDR_W{1'b0}};
                     ram_we   = 1'b0;
                     div_nx   = {DIV_W{1'b0}};
                  end
                  default: state_nx = IDLE;
               endcase
            end else begin
               state_nx = IDLE;
            end
         end
         FILL: begin
            if (stop) begin
               state_nx = IDLE;
            end else begin
               ram_addr    = fill_cnt;
               ram_we      = 1'b1;
               ram_wdata   = fill_val;
               fill_cnt_nx = fill_cnt + ADDR_W'(1);
               if (fill_cnt == ADDR_LAST) begin
                  state_nx = IDLE;
                  done_nx  = 1'b1;
               end else begin
                  state_nx = FILL;
               end
            end
         end
         SCAN: begin
            if (stop) begin
               state_nx = IDLE;
            end else if (div_cnt == DIV_LAST) begin
               div_nx   = {DIV_W{1'b0}};
               ram_addr = cur_addr + ADDR_W'(1);
               step_nx  = 1'b1;
            end else begin
               div_nx = div_cnt + DIV_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // FSM state, counters and registered status outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         fill_cnt <= {ADDR_W{1'b0}};
         fill_val <= {DATA_W{1'b0}};
         div_cnt  <= {DIV_W{1'b0}};
         busy     <= 1'b0;
         done     <= 1'b0;
         step     <= 1'b0;
      end else begin
         state    <= state_nx;
         fill_cnt <= fill_cnt_nx;
         fill_val <= fill_val_nx;
         div_cnt  <= div_nx;
         busy     <= (state_nx != IDLE);
         done     <= done_nx;
         step     <= step_nx;
      end
   end

   ram_sp #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clock  (clock),
      .reset  (reset),
      .addr   (ram_addr),
      .we     (ram_we),
      .wdata  (ram_wdata),
      .addr_q (cur_addr),
      .q      (q)
   );

endmodule

// File: tb/tb_ram_fill_scan.sv
// Directed bench for ram_fill_scan: a 4x32 instance (SCAN_DIV=4) and an 8x8 instance (SCAN_DIV=1).
module tb_ram_fill_scan;

   logic clock = 1'b0;
   logic reset;

   logic [1:0] a_mode;  logic a_start, a_stop, a_wren;
   logic [4:0] a_addr;  logic [3:0] a_wdata;
   logic a_busy, a_done, a_step;  logic [4:0] a_cur_addr;  logic [3:0] a_q;

   logic [1:0] b_mode;  logic b_start, b_stop, b_wren;
   logic [2:0] b_addr;  logic [7:0] b_wdata;
   logic b_busy, b_done, b_step;  logic [2:0] b_cur_addr;  logic [7:0] b_q;

   int checks = 0;
   int failures = 0;
   logic [3:0] exp_a [32];

   typedef struct {
      logic [1:0] mode;  logic start;  logic [4:0] addr;  logic [3:0] wdata;  logic wren;
      logic [4:0] e_addr;  logic q_chk;  logic [3:0] e_q;
   } vec_t;
   vec_t vecs [10];

   always #5 clock = ~clock;

   ram_fill_scan #(.DATA_W(4), .ADDR_W(5), .SCAN_DIV(4)) dut_a (
      .clock(clock), .reset(reset), .mode(a_mode), .start(a_start), .stop(a_stop),
      .addr(a_addr), .wdata(a_wdata), .wren(a_wren), .busy(a_busy), .done(a_done),
      .cur_addr(a_cur_addr), .q(a_q), .step(a_step));

   ram_fill_scan #(.DATA_W(8), .ADDR_W(3), .SCAN_DIV(1)) dut_b (
      .clock(clock), .reset(reset), .mode(b_mode), .start(b_start), .stop(b_stop),
      .addr(b_addr), .wdata(b_wdata), .wren(b_wren), .busy(b_busy), .done(b_done),
      .cur_addr(b_cur_addr), .q(b_q), .step(b_step));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic fill_a(input logic [3:0] val, input int stop_at, output int nb, output int nd);
      a_mode = 2'b01; a_wdata = val; a_start = 1'b1;
      tick();
      // These must all be ignored while filling.
      a_start = 1'b0; a_mode = 2'b00; a_wren = 1'b1; a_addr = 5'd3; a_wdata = 4'h5;
      nb = 0; nd = 0;
      for (int m = 1; m <= 100; m++) begin
         if (!a_busy) break;
         nb++;
         if (m == 4) a_wren = 1'b0;
         a_stop = (m == stop_at);
         tick();
         if (a_done) nd++;
      end
      a_stop = 1'b0; a_wren = 1'b0;
   endtask

   task automatic readback_a(input string tag);
      a_wren = 1'b0;
      for (int i = 0; i <= 32; i++) begin
         if (i < 32) a_addr = 5'(i);
         tick();
         if (i > 0) check(tag, 32'(a_q), 32'(exp_a[i-1]));
      end
   endtask

   initial begin
      int nb, nd;
      logic step_ok;

      reset = 1'b1;
      a_mode = 2'b00; a_start = 1'b0; a_stop = 1'b0; a_wren = 1'b0; a_addr = 5'd0; a_wdata = 4'h0;
      b_mode = 2'b00; b_start = 1'b0; b_stop = 1'b0; b_wren = 1'b0; b_addr = 3'd0; b_wdata = 8'h00;
      tick();
      check("reset_busy", 32'(a_busy), 32'd0);
      check("reset_done", 32'(a_done), 32'd0);
      check("reset_step", 32'(a_step), 32'd0);
      check("reset_cur_addr", 32'(a_cur_addr), 32'd0);
      check("reset_q", 32'(a_q), 32'd0);
      reset = 1'b0;

      // Manual access, including read-during-write and ignored start in modes 00/11.
      vecs[0] = '{2'b00, 1'b0, 5'd5,  4'h9, 1'b1, 5'd5,  1'b0, 4'h0};
      vecs[1] = '{2'b00, 1'b0, 5'd5,  4'h0, 1'b0, 5'd5,  1'b1, 4'h9};
      vecs[2] = '{2'b00, 1'b0, 5'd5,  4'h3, 1'b1, 5'd5,  1'b1, 4'h9};
      vecs[3] = '{2'b00, 1'b0, 5'd5,  4'h0, 1'b0, 5'd5,  1'b1, 4'h3};
      vecs[4] = '{2'b00, 1'b0, 5'd12, 4'hC, 1'b1, 5'd12, 1'b1, 4'h3};
      vecs[5] = '{2'b00, 1'b0, 5'd12, 4'h0, 1'b0, 5'd12, 1'b1, 4'hC};
      vecs[6] = '{2'b11, 1'b1, 5'd5,  4'h0, 1'b0, 5'd5,  1'b1, 4'hC};
      vecs[7] = '{2'b00, 1'b1, 5'd5,  4'h0, 1'b0, 5'd5,  1'b1, 4'h3};
      vecs[8] = '{2'b00, 1'b0, 5'd31, 4'h7, 1'b1, 5'd31, 1'b1, 4'h3};
      vecs[9] = '{2'b00, 1'b0, 5'd0,  4'h0, 1'b0, 5'd0,  1'b1, 4'h7};
      for (int v = 0; v < 10; v++) begin
         a_mode = vecs[v].mode; a_start = vecs[v].start; a_addr = vecs[v].addr;
         a_wdata = vecs[v].wdata; a_wren = vecs[v].wren;
         tick();
         check($sformatf("vec%0d_cur_addr", v), 32'(a_cur_addr), 32'(vecs[v].e_addr));
         check($sformatf("vec%0d_busy", v), 32'(a_busy), 32'd0);
         if (vecs[v].q_chk) check($sformatf("vec%0d_q", v), 32'(a_q), 32'(vecs[v].e_q));
      end
      a_start = 1'b0; a_wren = 1'b0; a_mode = 2'b00;

      // Full fill of 0xA.
      fill_a(4'hA, 0, nb, nd);
      check("fill_busy_cycles", 32'(nb), 32'd32);
      check("fill_done_count", 32'(nd), 32'd1);
      tick();
      check("fill_done_single", 32'(a_done), 32'd0);
      for (int i = 0; i < 32; i++) exp_a[i] = 4'hA;
      readback_a("fill_readback");

      // Clear, then fill 0x6 aborted on the 10th busy cycle.
      fill_a(4'h0, 0, nb, nd);
      for (int i = 0; i < 32; i++) exp_a[i] = 4'h0;
      fill_a(4'h6, 10, nb, nd);
      check("abort_busy_cycles", 32'(nb), 32'd10);
      check("abort_no_done", 32'(nd), 32'd0);
      check("abort_busy_low", 32'(a_busy), 32'd0);
      for (int i = 0; i < 9; i++) exp_a[i] = 4'h6;
      readback_a("abort_readback");

      // Preload a pattern and scan through one full wrap.
      for (int i = 0; i < 32; i++) begin
         exp_a[i] = 4'((i * 7 + 3) & 15);
         a_addr = 5'(i); a_wdata = exp_a[i]; a_wren = 1'b1;
         tick();
      end
      a_wren = 1'b0; a_mode = 2'b10; a_start = 1'b1;
      tick();
      a_start = 1'b0; a_mode = 2'b01;
      a_wren = 1'b1; a_addr = 5'd7; a_wdata = 4'h0;
      check("scan_entry_busy", 32'(a_busy), 32'd1);
      check("scan_entry_cur_addr", 32'(a_cur_addr), 32'd0);
      for (int s = 1; s <= 33; s++) begin
         step_ok = 1'b1;
         for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) check($sformatf("scan_q_%0d", s), 32'(a_q), 32'(exp_a[(s - 1) % 32]));
            if (a_step !== (k == 4)) step_ok = 1'b0;
         end
         check($sformatf("scan_step_timing_%0d", s), 32'(step_ok), 32'd1);
         check($sformatf("scan_cur_addr_%0d", s), 32'(a_cur_addr), 32'(s % 32));
      end
      a_stop = 1'b1; a_wren = 1'b0;
      tick();
      a_stop = 1'b0;
      check("scan_stop_busy", 32'(a_busy), 32'd0);
      readback_a("scan_readonly");

      // Asynchronous reset in the middle of a scan cycle.
      a_mode = 2'b10; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      check("pre_reset_cur_addr", 32'(a_cur_addr), 32'd1);
      #3 reset = 1'b1;
      #1;
      check("async_reset_busy", 32'(a_busy), 32'd0);
      check("async_reset_step", 32'(a_step), 32'd0);
      check("async_reset_done", 32'(a_done), 32'd0);
      check("async_reset_cur_addr", 32'(a_cur_addr), 32'd0);
      check("async_reset_q", 32'(a_q), 32'd0);
      a_mode = 2'b00;
      tick();
      reset = 1'b0;
      tick();
      check("post_reset_idle", 32'(a_busy), 32'd0);

      // stop beats start in IDLE.
      a_mode = 2'b01; a_start = 1'b1; a_stop = 1'b1; a_wdata = 4'hF;
      tick();
      check("prio_busy_1", 32'(a_busy), 32'd0);
      tick();
      check("prio_busy_2", 32'(a_busy), 32'd0);
      a_start = 1'b0; a_stop = 1'b0; a_mode = 2'b00;
      tick();
      check("prio_busy_3", 32'(a_busy), 32'd0);

      // 8x8 instance: fill 0xFF.
      b_mode = 2'b01; b_wdata = 8'hFF; b_start = 1'b1;
      tick();
      b_start = 1'b0; b_mode = 2'b00; b_wdata = 8'h00;
      nb = 0; nd = 0;
      for (int m = 1; m <= 50; m++) begin
         if (!b_busy) break;
         nb++;
         tick();
         if (b_done) nd++;
      end
      check("b_fill_busy_cycles", 32'(nb), 32'd8);
      check("b_fill_done_count", 32'(nd), 32'd1);
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) b_addr = 3'(i);
         tick();
         if (i > 0) check($sformatf("b_readback_%0d", i - 1), 32'(b_q), 32'hFF);
      end

      // SCAN_DIV=1 steps every cycle.
      b_mode = 2'b10; b_start = 1'b1;
      tick();
      b_start = 1'b0;
      check("b_scan_entry_cur_addr", 32'(b_cur_addr), 32'd0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         check($sformatf("b_scan_step_%0d", k), 32'(b_step), 32'd1);
         check($sformatf("b_scan_cur_addr_%0d", k), 32'(b_cur_addr), 32'(k));
         check($sformatf("b_scan_q_%0d", k), 32'(b_q), 32'hFF);
      end
      b_stop = 1'b1;
      tick();
      b_stop = 1'b0;
      check("b_scan_stop_busy", 32'(b_busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_fill_scan.md
Name: ram_fill_scan

Overview:
- Parametrised successor to the fixed 32x4 board RAM path: an inferred single-port synchronous RAM with a control FSM on top.
- Supports manual read/write, a hardware block-fill of the whole array, and a timed auto-scan readback for 7-segment display.
- Sits between board switches/keys and the hex decoders; the display logic stays outside this block.

Parameters:
- DATA_W, 4, word width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- SCAN_DIV, 50000000, clock cycles per scan step; legal range >= 1.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mode  in  2  operation mode: 00 manual, 01 fill, 10 scan, 11 reserved (treated as manual).
- start  in  1  level sampled in IDLE; launches fill or scan per mode.
- stop  in  1  aborts fill or scan.
- addr  in  ADDR_W  manual address.
- wdata  in  DATA_W  manual write data and fill value.
- wren  in  1  manual write enable.
- busy  out  1  high while in FILL or SCAN.
- done  out  1  one-cycle pulse when a fill completes normally.
- cur_addr  out  ADDR_W  address registered into the RAM this cycle.
- q  out  DATA_W  registered RAM read data.
- step  out  1  one-cycle pulse when scan advances.

Behaviour:
- Reset (async, any time):
  - state goes to IDLE; busy, done, step, cur_addr, q, fill counter and divider all go to 0.
  - RAM contents are not cleared; a reset mid-fill leaves a partially written array.
- RAM:
  - Single port; the address is registered at each edge, and q shows the word at that address on the following edge (read latency 1).
  - Read-during-write returns the OLD data.
- States: IDLE, FILL, SCAN.
- IDLE:
  - cur_addr <= addr each edge; a write occurs when wren=1.
  - stop=1 has priority over start, and the block stays in IDLE.
  - start=1 with mode=01 -> FILL: fill value latched from wdata, counter = 0.
  - start=1 with mode=10 -> SCAN: cur_addr = 0, divider = 0.
  - start with mode 00/11 is ignored.
- FILL:
  - Writes the latched value to address k on the k-th edge after entry, k = 0..2**ADDR_W-1, one word per cycle; cur_addr = k.
  - After writing the last address: state -> IDLE and done=1 for exactly one cycle.
  - Total busy time is 2**ADDR_W cycles.
  - wren, addr, wdata, start and mode are ignored.
  - stop=1 -> IDLE on the next edge; the address in flight that edge is not written; done is not asserted.
- SCAN:
  - Read-only. The divider counts 0..SCAN_DIV-1.
  - On wrap, cur_addr increments and step pulses for one cycle; q updates one cycle later.
  - cur_addr wraps from 2**ADDR_W-1 to 0 and the scan runs until stop.
  - wren, start and mode are ignored.
  - stop=1 -> IDLE next edge.
  - SCAN_DIV=1 advances every cycle.
- Width rules: all address arithmetic is modulo 2**ADDR_W, and the divider is sized by clog2(SCAN_DIV).
- A mode change while busy has no effect; mode is only sampled in IDLE with start.

Decomposition:
- Shared package holds:
  - mode encodings MODE_MANUAL/MODE_FILL/MODE_SCAN;
  - state enum IDLE/FILL/SCAN.
- One sub-module, ram_sp: parametrised (DATA_W, ADDR_W) single-port inferred RAM with registered address and read-old-data semantics.
- FSM, fill counter and scan divider live in ram_fill_scan.

Test Plan:
- Reset check: assert reset mid-cycle in SCAN -> busy, done, step, cur_addr and q become 0 immediately; state IDLE.
- Manual write/read: write 0x9 at addr 5, then read addr 5 -> q=0x9 one cycle after the address edge. Write 0x3 at addr 5 while reading it -> q=0x9 (old data), then 0x3 on the next read.
- Fill: mode=01, wdata=0xA, start pulse -> busy for exactly 32 cycles, done pulses once. A read of every address 0..31 -> 0xA.
- Fill abort: start a fill of 0x6 over an all-0x0 array and assert stop on the 10th busy cycle -> addresses 0..8 = 0x6 and 9..31 = 0x0, no done, busy drops.
- Scan wrap: SCAN_DIV=4, ADDR_W=5, mode=10, start -> step every 4 cycles, cur_addr 0,1,...,31,0. q matches the preloaded pattern one cycle after each step. stop -> IDLE next edge.
- Priority: start=1 and stop=1 together in IDLE with mode=01 -> no fill, busy stays 0. DATA_W=8, ADDR_W=3 instance: fill 0xFF -> 8 busy cycles, all words 0xFF.
